d_sram_like_to_axi: RTL and testbench
=====================================

D_SRAM_LIKE_TO_AXI -- requirements
Module: d_sram_like_to_axi

Interface
REQ-001 SHALL have parameter ID_W, default 4, width of all AXI ID fields.
REQ-002 SHALL have parameter DATA_ID, default 1, constant value driven on arid/awid/wid.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port data_req  input  1  sram-like request valid.
REQ-006 SHALL have port data_wr  input  1  1 = write, 0 = read.
REQ-007 SHALL have port data_size  input  2  0 = byte, 1 = half, 2 = word.
REQ-008 SHALL have port data_addr  input  32  physical byte address.
REQ-009 SHALL have port data_wdata  input  32  write data, lane-aligned.
REQ-010 SHALL have port data_addr_ok  output  1  request accepted this cycle.
REQ-011 SHALL have port data_data_ok  output  1  one-cycle completion pulse.
REQ-012 SHALL have port data_rdata  output  32  read data, valid with data_data_ok.
REQ-013 SHALL have AR channel ports: arid[ID_W], araddr[32], arlen[4], arsize[3], arburst[2], arvalid as outputs; arready as input.
REQ-014 SHALL have R channel ports: rid[ID_W], rdata[32], rresp[2], rlast, rvalid as inputs; rready as output.
REQ-015 SHALL have AW channel ports: awid[ID_W], awaddr[32], awlen[4], awsize[3], awburst[2], awvalid as outputs; awready as input.
REQ-016 SHALL have W channel ports: wid[ID_W], wdata[32], wstrb[4], wlast, wvalid as outputs; wready as input.
REQ-017 SHALL have B channel ports: bid[ID_W], bresp[2], bvalid as inputs; bready as output.

Function
REQ-018 SHALL allow one outstanding transaction; FSM states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
REQ-019 SHALL drive data_addr_ok = data_req while in IDLE, 0 in every other state (combinational).
REQ-020 SHALL, on data_req & data_addr_ok, latch wr/size/addr/wdata and move to RD_ADDR (wr=0) or WR_REQ (wr=1).
REQ-021 SHALL hold arvalid=1 in RD_ADDR; on arready go to RD_DATA with arvalid=0 next cycle.
REQ-022 SHALL hold rready=1 in RD_DATA; on rvalid, register rdata into data_rdata, pulse data_data_ok next cycle, return to IDLE.
REQ-023 SHALL, in WR_REQ, assert awvalid and wvalid together; each deasserts independently after its own handshake; both done (same or different cycles) -> WR_RESP.
REQ-024 SHALL hold bready=1 in WR_RESP; on bvalid pulse data_data_ok next cycle and return to IDLE.
REQ-025 SHALL drive arlen=awlen=0, arburst=awburst=2'b01, wlast=1, arsize=awsize={1'b0,size}.
REQ-026 SHALL generate wstrb: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111; size=3 treated as word.
REQ-027 SHALL hold all AXI payloads stable while the matching valid is high; rresp/bresp errors ignored, rid/bid not checked.
REQ-028 SHALL accept the next request no earlier than the cycle after data_data_ok (back-to-back minimum: 1 idle cycle).

Reset
REQ-029 SHALL, on rst, enter IDLE asynchronously; all valid/ready outputs, data_data_ok 0; data_rdata 0; latched request cleared, including mid-transaction.

Configuration
REQ-030 SHALL, with D_AXI_WRITE_EARLY_ACK_EN defined, pulse data_data_ok for writes the cycle after both AW and W complete, then wait in WR_RESP for bvalid with data_addr_ok held 0.
REQ-031 SHALL, without D_AXI_WRITE_EARLY_ACK_EN, pulse data_data_ok for writes only after the B handshake.

Structure
REQ-032 SHALL take FSM state enum, AXI burst/size constants and DATA_ID default from shared package axi_pkg.
REQ-033 SHALL place strobe generation in combinational sub-module d_axi_wstrb_gen (size, addr[1:0] -> wstrb).

Verification
REQ-034 Read word 0x1FC0_0004, arready after 2 cycles, rdata 0xDEADBEEF -> arsize 2, data_data_ok one pulse, data_rdata 0xDEADBEEF.
REQ-035 Write byte addr 0x...03, wdata 0x11223344 -> wstrb 4'b1000, awsize 0, wlast 1, data_ok after bvalid.
REQ-036 Write half addr 0x...02, awready cycle 1, wready cycle 4 -> WR_RESP only after cycle 4, awvalid low from cycle 2.
REQ-037 rst asserted while in RD_DATA -> next cycle IDLE, arvalid/rready/data_data_ok 0, no spurious data_ok.
REQ-038 With D_AXI_WRITE_EARLY_ACK_EN, write then read request, bvalid delayed 5 cycles -> write data_ok early, read addr_ok withheld until B done.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI constants for the sram-like bridge: FSM state codes, burst/size encodings
// and the default transaction ID.
package axi_pkg;

    typedef logic [2:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE    = 3'd0;
    localparam fsm_state_t ST_RD_ADDR = 3'd1;
    localparam fsm_state_t ST_RD_DATA = 3'd2;
    localparam fsm_state_t ST_WR_REQ  = 3'd3;
    localparam fsm_state_t ST_WR_RESP = 3'd4;

    localparam logic [1:0] BURST_INCR = 2'b01;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int DATA_ID_DEFAULT = 1;

    function automatic logic [2:0] axsize(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/d_sram_like_to_axi_if.sv
// AXI3 channel bundle (AR/R/AW/W/B) between the sram-like bridge and the bus fabric.
interface d_sram_like_to_axi_if #(
    parameter int ID_W = 4
) ();
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [3:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [3:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready;

    logic [ID_W-1:0] wid;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/d_axi_wstrb_gen.sv
// Byte-lane write strobe from transfer size and low address bits; size 3 is treated as word.
module d_axi_wstrb_gen
    import axi_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr,
    output logic [3:0] wstrb
);

    always_comb begin
        wstrb = 4'b1111;
        case (size)
            SIZE_BYTE: wstrb = 4'b0001 << addr;
            SIZE_HALF: wstrb = 4'b0011 << {addr[1], 1'b0};
            default:   wstrb = 4'b1111;
        endcase
    end

endmodule

// File: rtl/d_sram_like_to_axi.sv
// Single-outstanding sram-like to AXI3 bridge for the data port.
// Define D_AXI_WRITE_EARLY_ACK_EN to acknowledge writes once AW and W are both accepted.
module d_sram_like_to_axi
    import axi_pkg::*;
#(
    parameter int ID_W    = 4,
    parameter int DATA_ID = DATA_ID_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [31:0]         data_addr,
    input  logic [31:0]         data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [31:0]         data_rdata,
    d_sram_like_to_axi_if.master axi
);

    fsm_state_t  state;
    logic        req_wr;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        aw_done;
    logic        w_done;
    logic        aw_hs;
    logic        w_hs;
    logic        wr_both;
    logic [3:0]  wstrb;
    logic        unused_axi;

    assign aw_hs   = axi.awvalid & axi.awready;
    assign w_hs    = axi.wvalid & axi.wready;
    assign wr_both = (aw_done | aw_hs) & (w_done | w_hs);

    // The completion cycle itself is never an accept cycle: at least one gap between requests.
    assign data_addr_ok = (state == ST_IDLE) & ~data_data_ok & data_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            req_wr       <= 1'b0;
            req_size     <= 2'd0;
            req_addr     <= 32'd0;
            req_wdata    <= 32'd0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            data_data_ok <= 1'b0;
            data_rdata   <= 32'd0;
        end else begin
            data_data_ok <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (data_req && data_addr_ok) begin
                        req_wr    <= data_wr;
                        req_size  <= data_size;
                        req_addr  <= data_addr;
                        req_wdata <= data_wdata;
                        state     <= data_wr ? ST_WR_REQ : ST_RD_ADDR;
                    end
                end
                ST_RD_ADDR: begin
                    if (axi.arready) state <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (axi.rvalid) begin
                        data_rdata   <= axi.rdata;
                        data_data_ok <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end
                ST_WR_REQ: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                    if (wr_both) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= ST_WR_RESP;
`ifdef D_AXI_WRITE_EARLY_ACK_EN
                        data_data_ok <= 1'b1;
`endif
                    end
                end
                ST_WR_RESP: begin
                    if (axi.bvalid) begin
                        state <= ST_IDLE;
`ifndef D_AXI_WRITE_EARLY_ACK_EN
                        data_data_ok <= 1'b1;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    d_axi_wstrb_gen u_wstrb_gen (
        .size  (req_size),
        .addr  (req_addr[1:0]),
        .wstrb (wstrb)
    );

    assign axi.arid    = ID_W'(DATA_ID);
    assign axi.araddr  = req_addr;
    assign axi.arlen   = 4'd0;
    assign axi.arsize  = axsize(req_size);
    assign axi.arburst = BURST_INCR;
    assign axi.arvalid = (state == ST_RD_ADDR);
    assign axi.rready  = (state == ST_RD_DATA);

    assign axi.awid    = ID_W'(DATA_ID);
    assign axi.awaddr  = req_addr;
    assign axi.awlen   = 4'd0;
    assign axi.awsize  = axsize(req_size);
    assign axi.awburst = BURST_INCR;
    assign axi.awvalid = (state == ST_WR_REQ) & ~aw_done;

    assign axi.wid     = ID_W'(DATA_ID);
    assign axi.wdata   = req_wdata;
    assign axi.wstrb   = wstrb;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = (state == ST_WR_REQ) & ~w_done;
    assign axi.bready  = (state == ST_WR_RESP);

    // Response IDs and error codes are deliberately ignored.
    assign unused_axi = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp, req_wr};

endmodule

// File: tb/tb_d_sram_like_to_axi.sv
// Bench for d_sram_like_to_axi: directed vector table, reset-abort sequence and randomized transactions.
module tb_d_sram_like_to_axi;

`ifdef D_AXI_WRITE_EARLY_ACK_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    always #5 clk = ~clk;

    d_sram_like_to_axi_if #(.ID_W(4)) axi ();

    d_sram_like_to_axi #(.ID_W(4), .DATA_ID(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .axi          (axi)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ar_d;
        int          r_d;
        int          aw_d;
        int          w_d;
        int          b_d;
        logic [3:0]  exp_strb;
        logic [2:0]  exp_axsize;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Lane model: byte -> lane addr%4, half -> lower or upper pair, anything else full word.
    function automatic logic [3:0] m_strb(input logic [1:0] size, input logic [31:0] addr);
        int lane;
        lane = addr % 4;
        if (size == 2'd0) return 4'(1 << lane);
        if (size == 2'd1) return (lane >= 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic slave_idle();
        axi.arready = 0; axi.rvalid = 0; axi.rid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bid = 0; axi.bresp = 0;
    endtask

    task automatic run_txn(input vec_t v);
        int  k, ok_k, ok_cnt, arv, rr, awv, wv, br, bready_first, exp_ok;
        bit  pay_ok, done;
        logic [31:0] ok_rdata;
        ok_k = -1; ok_cnt = 0; arv = 0; rr = 0; awv = 0; wv = 0; br = 0;
        bready_first = -1; pay_ok = 1; done = 0; ok_rdata = 0;

        @(negedge clk);
        data_req = 1; data_wr = v.wr; data_size = v.size; data_addr = v.addr; data_wdata = v.wdata;
        #1;
        chk("addr_ok_idle", data_addr_ok, 1'b1);

        for (k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            data_req = 0; data_size = ~v.size; data_addr = ~v.addr; data_wdata = ~v.wdata;
            if (data_data_ok) begin ok_cnt++; ok_k = k; ok_rdata = data_rdata; end
            if (axi.arvalid) begin
                arv++;
                if (axi.araddr !== v.addr || axi.arsize !== v.exp_axsize || axi.arlen !== 4'd0 ||
                    axi.arburst !== 2'b01 || axi.arid !== 4'd1) pay_ok = 0;
            end
            if (axi.awvalid) begin
                awv++;
                if (axi.awaddr !== v.addr || axi.awsize !== v.exp_axsize || axi.awlen !== 4'd0 ||
                    axi.awburst !== 2'b01 || axi.awid !== 4'd1) pay_ok = 0;
            end
            if (axi.wvalid) begin
                wv++;
                if (axi.wdata !== v.wdata || axi.wstrb !== v.exp_strb || axi.wlast !== 1'b1 ||
                    axi.wid !== 4'd1) pay_ok = 0;
            end
            if (axi.rready) rr++;
            if (axi.bready) begin br++; if (bready_first < 0) bready_first = k; end

            axi.arready = axi.arvalid && (arv > v.ar_d);
            axi.awready = axi.awvalid && (awv > v.aw_d);
            axi.wready  = axi.wvalid && (wv > v.w_d);
            axi.rvalid  = axi.rready && (rr > v.r_d);
            axi.rdata   = v.rdata;
            axi.rlast   = 1'b1;
            axi.rresp   = 2'b10;
            axi.bvalid  = axi.bready && (br > v.b_d);
            axi.bresp   = 2'b10;

            if (ok_cnt > 0 && (k == ok_k || axi.bready)) begin
                data_req = 1; data_wr = 0;
                #1;
                chk("addr_ok_withheld", data_addr_ok, 1'b0);
                data_req = 0;
            end

            if (ok_cnt > 0 && k > ok_k && !axi.bready && !axi.rready && !axi.arvalid &&
                !axi.awvalid && !axi.wvalid) done = 1;
        end
        if (!done) chk("txn_timeout", 1'b1, 1'b0);

        if (!v.wr) exp_ok = v.ar_d + 1 + v.r_d + 1;
        else if (EARLY) exp_ok = max2(v.aw_d, v.w_d) + 1;
        else exp_ok = max2(v.aw_d, v.w_d) + 1 + v.b_d + 1;

        chk("data_ok_pulses", ok_cnt, 1);
        chk("data_ok_cycle", ok_k, exp_ok);
        chk("payload", pay_ok, 1'b1);
        if (!v.wr) begin
            chk("arvalid_cycles", arv, v.ar_d + 1);
            chk("rdata", ok_rdata, v.rdata);
        end else begin
            chk("awvalid_cycles", awv, v.aw_d + 1);
            chk("wvalid_cycles", wv, v.w_d + 1);
            chk("wr_resp_entry", bready_first, max2(v.aw_d, v.w_d) + 1);
            chk("bready_cycles", br, v.b_d + 1);
        end
    endtask

    vec_t tbl[7];
    vec_t rv;

    initial begin
        tbl[0] = '{1'b0, 2'd2, 32'h1FC0_0004, 32'h0,         32'hDEAD_BEEF, 2, 1, 0, 0, 0, 4'b1111, 3'd2};
        tbl[1] = '{1'b1, 2'd0, 32'h1FC0_0003, 32'h1122_3344, 32'h0,         0, 0, 0, 0, 2, 4'b1000, 3'd0};
        tbl[2] = '{1'b1, 2'd1, 32'h1FC0_0002, 32'hAABB_CCDD, 32'h0,         0, 0, 1, 4, 0, 4'b1100, 3'd1};
        tbl[3] = '{1'b1, 2'd2, 32'h0000_0100, 32'hCAFE_F00D, 32'h0,         0, 0, 2, 0, 5, 4'b1111, 3'd2};
        tbl[4] = '{1'b0, 2'd0, 32'h0000_0101, 32'h0,         32'h1234_5678, 0, 0, 0, 0, 0, 4'b1111, 3'd0};
        tbl[5] = '{1'b1, 2'd3, 32'h8000_0001, 32'h0102_0304, 32'h0,         0, 0, 0, 3, 1, 4'b1111, 3'd3};
        tbl[6] = '{1'b1, 2'd0, 32'h8000_0011, 32'h5566_7788, 32'h0,         3, 0, 3, 3, 0, 4'b0010, 3'd0};

        slave_idle();
        rst = 1; data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valids", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}, 5'd0);
        chk("rst_data_ok", data_data_ok, 1'b0);
        chk("rst_rdata", data_rdata, 32'd0);
        chk("rst_addr_ok", data_addr_ok, 1'b0);
        rst = 0;

        for (int i = 0; i < 7; i++) run_txn(tbl[i]);

        // Reset while the read sits in RD_DATA with a response about to arrive.
        @(negedge clk);
        data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h0000_0040;
        @(negedge clk);
        data_req = 0; axi.arready = 1;
        @(negedge clk);
        axi.arready = 0;
        chk("abort_in_rd_data", axi.rready, 1'b1);
        rst = 1; axi.rvalid = 1; axi.rdata = 32'h0BAD_0BAD;
        #1;
        chk("abort_async", {axi.rready, axi.arvalid, data_data_ok}, 3'd0);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_quiet", {axi.rready, axi.arvalid, axi.awvalid, axi.wvalid, axi.bready, data_data_ok}, 6'd0);
            chk("abort_rdata", data_rdata, 32'd0);
        end
        slave_idle();

        for (int i = 0; i < 40; i++) begin
            rv.wr    = 1'($urandom_range(0, 1));
            rv.size  = 2'($urandom_range(0, 3));
            rv.addr  = $urandom;
            rv.wdata = $urandom;
            rv.rdata = $urandom;
            rv.ar_d  = $urandom_range(0, 3);
            rv.r_d   = $urandom_range(0, 3);
            rv.aw_d  = $urandom_range(0, 3);
            rv.w_d   = $urandom_range(0, 3);
            rv.b_d   = $urandom_range(0, 5);
            rv.exp_strb   = m_strb(rv.size, rv.addr);
            rv.exp_axsize = {1'b0, rv.size};
            run_txn(rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
